pipe_if_id: RTL
===============

PIPE_IF_ID -- requirements
Module: pipe_if_id

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-003 SHALL: pc_IF  input  32  PC of the fetched instruction.
REQ-004 SHALL: npc_IF  input  32  PC+4 of the fetched instruction.
REQ-005 SHALL: inst_IF  input  32  instruction word from IMEM.
REQ-006 SHALL: inst_valid_IF  input  1  IMEM response valid this cycle.
REQ-007 SHALL: inst_ready_IF  output  1  block can accept an IMEM response this cycle.
REQ-008 SHALL: stall_ID  input  1  hazard unit holds the ID stage.
REQ-009 SHALL: flush_ID  input  1  taken branch/jump; kill ID contents and wrong-path fetch.
REQ-010 SHALL: valid_ID, pc_ID[31:0], npc_ID[31:0], inst_ID[31:0]  outputs  ID-stage instruction and its valid bit.

Function
REQ-011 SHALL: internal state = output register (valid_ID, pc_ID, npc_ID, inst_ID) plus one-entry skid register (skid_valid, skid_pc, skid_npc, skid_inst).
REQ-012 SHALL: inst_ready_IF = ~skid_valid, purely from registered state (no combinational path from stall_ID/flush_ID).
REQ-013 SHALL: accept = inst_valid_IF & inst_ready_IF; inputs not accepted are ignored and not retained.
REQ-014 SHALL: per-edge priority flush_ID > stall_ID > advance.
REQ-015 SHALL: flush: valid_ID<=0, pc_ID/npc_ID/inst_ID<=0, skid_valid<=0; a response accepted in the same cycle is discarded.
REQ-016 SHALL: stall (no flush): output register holds all values; if accept, load skid with inputs, skid_valid<=1.
REQ-017 SHALL: advance with skid_valid=1: output register<=skid contents, valid_ID<=1, skid_valid<=0 (accept impossible since ready=0).
REQ-018 SHALL: advance with skid_valid=0 and accept: output register<=inputs, valid_ID<=1 (latency one cycle IF->ID).
REQ-019 SHALL: advance with skid_valid=0 and no accept: bubble -- valid_ID<=0, pc_ID/npc_ID/inst_ID<=0 (inst 0 = NOP).
REQ-020 SHALL: instruction order preserved; no response is ever dropped or duplicated except by flush.
REQ-021 SHALL: flush and stall asserted together behave as flush only.

Reset
REQ-022 SHALL: while rst=0, valid_ID=0, pc_ID=npc_ID=inst_ID=0, skid_valid=0, skid data=0, inst_ready_IF=1; inputs ignored.
REQ-023 SHALL: reset asserted mid-stall with skid full discards skid contents immediately (asynchronous).
REQ-024 SHALL: first edge after rst deasserts follows REQ-014..019 normally.

Configuration
REQ-025 SHALL: macro PIPE_IF_ID_PERF_EN defined: add outputs stall_cnt[31:0], flush_cnt[31:0], bubble_cnt[31:0].
REQ-026 SHALL: stall_cnt +1 per edge with stall_ID=1 & flush_ID=0; flush_cnt +1 per edge with flush_ID=1; bubble_cnt +1 per REQ-019 edge.
REQ-027 SHALL: counters saturate at 32'hFFFFFFFF and reset to 0 with rst.
REQ-028 SHALL: macro undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-029 SHALL: back-to-back: accept pc=0x00400000,inst=0x20080005 then pc=0x00400004 -> valid_ID=1, pc_ID=0x00400000 one edge later, 0x00400004 next edge.
REQ-030 SHALL: stall 2 cycles while response pc=0x00400008 arrives -> output holds, inst_ready_IF=0 after first edge, pc_ID=0x00400008 on first edge after stall drops.
REQ-031 SHALL: flush with skid full and inst_valid_IF=1 -> next edge valid_ID=0, inst_ID=0, inst_ready_IF=1, no flushed PC ever reaches pc_ID.
REQ-032 SHALL: flush_ID=1 & stall_ID=1 same cycle -> same result as flush alone.
REQ-033 SHALL: rst=0 asynchronously mid-stall -> outputs 0 and inst_ready_IF=1 before next clk edge.
REQ-034 SHALL: with PIPE_IF_ID_PERF_EN, 3 stall cycles + 1 flush + 2 idle cycles -> stall_cnt=3, flush_cnt=1, bubble_cnt=2.

Source files
------------

// File: rtl/pipe_if_id.sv
// -----------------------------------------------------------------------------
// pipe_if_id : IF->ID pipeline register with a one-entry skid buffer.
//
// The output register holds the instruction currently in ID. When ID is
// stalled and IMEM still returns a response, that response is parked in the
// skid register. While the skid is occupied, inst_ready_IF drops, so IMEM
// back-pressure comes from registered state only and never from stall/flush.
// Per-edge priority is flush > stall > advance. Flush also kills the skid
// entry, because it holds a wrong-path fetch.
//
// Optional feature: define PIPE_IF_ID_PERF_EN to add saturating 32-bit
// stall/flush/bubble event counters as extra outputs.
// -----------------------------------------------------------------------------
module pipe_if_id (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active-low
  input  logic [31:0] pc_IF,
  input  logic [31:0] npc_IF,
  input  logic [31:0] inst_IF,
  input  logic        inst_valid_IF,
  output logic        inst_ready_IF,
  input  logic        stall_ID,
  input  logic        flush_ID,
  output logic        valid_ID,
  output logic [31:0] pc_ID,
  output logic [31:0] npc_ID,
  output logic [31:0] inst_ID
`ifdef PIPE_IF_ID_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  logic        r_skid_valid;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_npc;
  logic [31:0] r_skid_inst;

  logic        w_accept;

  // Ready depends only on skid occupancy, which keeps it glitch-free w.r.t. hazards.
  assign inst_ready_IF = ~r_skid_valid;
  assign w_accept      = inst_valid_IF & ~r_skid_valid;

  // Output register and skid register update: flush > stall > advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the skid data is cleared as well as its valid bit, so no stale
      // instruction bits from before reset remain visible in the block.
      valid_ID     <= 1'b0;
      pc_ID        <= '0;
      npc_ID       <= '0;
      inst_ID      <= '0;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_npc   <= '0;
      r_skid_inst  <= '0;
    end else if (flush_ID) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge state, so the order of these statements does not matter.
      valid_ID     <= 1'b0;
      pc_ID        <= '0;
      npc_ID       <= '0;
      inst_ID      <= '0;
      r_skid_valid <= 1'b0;
    end else if (stall_ID) begin
      if (w_accept) begin
        r_skid_valid <= 1'b1;
        r_skid_pc    <= pc_IF;
        r_skid_npc   <= npc_IF;
        r_skid_inst  <= inst_IF;
      end
    end else if (r_skid_valid) begin
      // Drain the parked response first to preserve program order.
      valid_ID     <= 1'b1;
      pc_ID        <= r_skid_pc;
      npc_ID       <= r_skid_npc;
      inst_ID      <= r_skid_inst;
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      valid_ID <= 1'b1;
      pc_ID    <= pc_IF;
      npc_ID   <= npc_IF;
      inst_ID  <= inst_IF;
    end else begin
      // Bubble: nothing to hand to ID, present a NOP.
      valid_ID <= 1'b0;
      pc_ID    <= '0;
      npc_ID   <= '0;
      inst_ID  <= '0;
    end
  end

`ifdef PIPE_IF_ID_PERF_EN
  logic w_stall_evt;
  logic w_bubble_evt;

  assign w_stall_evt  = stall_ID & ~flush_ID;
  assign w_bubble_evt = ~flush_ID & ~stall_ID & ~r_skid_valid & ~w_accept;

  // Saturating event counters for pipeline occupancy statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (w_stall_evt && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush_ID && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
      if (w_bubble_evt && (bubble_cnt != 32'hFFFF_FFFF))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
